// File: rtl/trace_line_arbiter.sv
// rtl/trace_line_arbiter.sv - line-granular round-robin arbiter feeding one cpu_checker char stream; optional LINE_STATS_EN counters
module trace_line_arbiter #(
  parameter int N_REQ    = 4,
  parameter int IDX_W    = 2,
  parameter int MAX_LINE = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [8*N_REQ-1:0]   req_char_i,
  output logic [N_REQ-1:0]     req_ready_o,
  output logic [7:0]           out_char_o,
  input  logic [1:0]           chk_format_type_i,
  input  logic [3:0]           chk_error_code_i,
  output logic                 res_valid_o,
  output logic [IDX_W-1:0]     res_id_o,
  output logic [1:0]           res_format_o,
  output logic [3:0]           res_error_o,
  output logic                 res_abort_o,
  output logic                 busy_o
`ifdef LINE_STATS_EN
  ,
  output logic [15:0]          line_count_o,
  output logic [15:0]          bad_count_o
`endif
);

  localparam int         LEN_W    = $clog2(MAX_LINE) + 1;
  localparam logic [7:0] EOL_CHAR = 8'h23;
  localparam logic [7:0] NUL_CHAR = 8'h00;

  typedef enum logic [1:0] {IDLE, STREAM, WAIT1, WAIT2} state_t;

  state_t             state_q;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [LEN_W-1:0]   len_q;
  logic [N_REQ-1:0]   req_ready_q;
  logic [7:0]         out_char_q;
  logic               res_valid_q;
  logic [IDX_W-1:0]   res_id_q;
  logic [1:0]         res_format_q;
  logic [3:0]         res_error_q;
  logic               res_abort_q;

  logic [IDX_W-1:0]   pick_d;
  logic [N_REQ-1:0]   pick_onehot_d;
  logic [7:0]         gchar_d;
  logic               xfer_d;
  logic               abort_d;

  // First valid requester strictly after ptr, wrapping around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] valid,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] sel;
    logic             hit;
    int               idx;
    sel = '0;
    hit = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!hit && valid[idx]) begin
        sel = IDX_W'(idx);
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

  // Arbitration pick, granted character, and transfer/abort decode
  always_comb begin
    pick_d                = rr_pick(req_valid_i, rr_ptr_q);
    pick_onehot_d         = '0;
    pick_onehot_d[pick_d] = 1'b1;
    gchar_d               = req_char_i[8*grant_q +: 8];
    xfer_d                = |(req_valid_i & req_ready_q);
    // A stall, or a non-terminating character filling the last slot, ends the line early.
    abort_d               = !xfer_d ||
                            ((gchar_d != EOL_CHAR) && (len_q == LEN_W'(MAX_LINE - 1)));
  end

  // Line-grant FSM with registered stream and verdict outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      rr_ptr_q     <= IDX_W'(N_REQ - 1);
      len_q        <= '0;
      req_ready_q  <= '0;
      out_char_q   <= NUL_CHAR;
      res_valid_q  <= 1'b0;
      res_id_q     <= '0;
      res_format_q <= 2'd0;
      res_error_q  <= 4'd0;
      res_abort_q  <= 1'b0;
    end else begin
      res_valid_q <= 1'b0;
      out_char_q  <= NUL_CHAR;
      case (state_q)
        IDLE: begin
          if (|req_valid_i) begin
            grant_q     <= pick_d;
            rr_ptr_q    <= pick_d;
            len_q       <= '0;
            req_ready_q <= pick_onehot_d;
            state_q     <= STREAM;
          end
        end
        STREAM: begin
          if (xfer_d) begin
            out_char_q <= gchar_d;
            len_q      <= len_q + LEN_W'(1);
          end
          if (abort_d) begin
            req_ready_q  <= '0;
            res_valid_q  <= 1'b1;
            res_abort_q  <= 1'b1;
            res_format_q <= 2'd0;
            res_error_q  <= 4'd0;
            res_id_q     <= grant_q;
            state_q      <= IDLE;
          end else if (gchar_d == EOL_CHAR) begin
            req_ready_q <= '0;
            state_q     <= WAIT1;
          end
        end
        WAIT1: begin
          // The checker latches '#' on the next edge; its verdict follows one cycle later.
          state_q <= WAIT2;
        end
        WAIT2: begin
          res_valid_q  <= 1'b1;
          res_abort_q  <= 1'b0;
          res_format_q <= chk_format_type_i;
          res_error_q  <= chk_error_code_i;
          res_id_q     <= grant_q;
          state_q      <= IDLE;
        end
        default: begin
          req_ready_q <= '0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign out_char_o   = out_char_q;
  assign res_valid_o  = res_valid_q;
  assign res_id_o     = res_id_q;
  assign res_format_o = res_format_q;
  assign res_error_o  = res_error_q;
  assign res_abort_o  = res_abort_q;
  assign busy_o       = (state_q != IDLE);

`ifdef LINE_STATS_EN
  logic [15:0] line_count_q;
  logic [15:0] bad_count_q;
  logic        bad_line_d;

  assign bad_line_d = res_abort_q | (res_format_q == 2'd0) | (res_error_q != 4'd0);

  // Saturating line statistics, counted off the registered verdict pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      line_count_q <= 16'h0000;
      bad_count_q  <= 16'h0000;
    end else if (res_valid_q) begin
      if (line_count_q != 16'hFFFF) line_count_q <= line_count_q + 16'h0001;
      if (bad_line_d && (bad_count_q != 16'hFFFF)) bad_count_q <= bad_count_q + 16'h0001;
    end
  end

  assign line_count_o = line_count_q;
  assign bad_count_o  = bad_count_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_trace_line_arbiter.sv
// tb/tb_trace_line_arbiter.sv - table-driven scoreboard bench for trace_line_arbiter
module tb_trace_line_arbiter;
  localparam int N_REQ    = 4;
  localparam int IDX_W    = 2;
  localparam int MAX_LINE = 64;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N_REQ-1:0]     req_valid_i;
  logic [8*N_REQ-1:0]   req_char_i;
  logic [N_REQ-1:0]     req_ready_o;
  logic [7:0]           out_char_o;
  logic [1:0]           chk_format_type_i;
  logic [3:0]           chk_error_code_i;
  logic                 res_valid_o;
  logic [IDX_W-1:0]     res_id_o;
  logic [1:0]           res_format_o;
  logic [3:0]           res_error_o;
  logic                 res_abort_o;
  logic                 busy_o;
`ifdef LINE_STATS_EN
  logic [15:0]          line_count_o;
  logic [15:0]          bad_count_o;
`endif

  trace_line_arbiter #(.N_REQ(N_REQ), .IDX_W(IDX_W), .MAX_LINE(MAX_LINE)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid_i       (req_valid_i),
    .req_char_i        (req_char_i),
    .req_ready_o       (req_ready_o),
    .out_char_o        (out_char_o),
    .chk_format_type_i (chk_format_type_i),
    .chk_error_code_i  (chk_error_code_i),
    .res_valid_o       (res_valid_o),
    .res_id_o          (res_id_o),
    .res_format_o      (res_format_o),
    .res_error_o       (res_error_o),
    .res_abort_o       (res_abort_o),
    .busy_o            (busy_o)
`ifdef LINE_STATS_EN
    ,
    .line_count_o      (line_count_o),
    .bad_count_o       (bad_count_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [1:0] fmt;
    logic [3:0] err;
    logic       abort;
  } res_t;

  typedef struct {
    int         req;
    string      line;
    int         stall;
    logic [1:0] fmt;
    logic [3:0] err;
    logic       abort;
    int         sent;
  } vec_t;

  res_t       exp_q[$];
  int         n_vec    = 0;
  int         n_miss   = 0;
  int         cyc      = 0;
  int         hash_cyc = -100;
  logic [7:0] exp_next = 8'h00;
  bit         mon_en   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input int req, input string line, input int stall,
                              input logic [1:0] fmt, input logic [3:0] err,
                              input logic ab, input int sent);
    vec_t v;
    v.req = req; v.line = line; v.stall = stall;
    v.fmt = fmt; v.err = err; v.abort = ab; v.sent = sent;
    return v;
  endfunction

  function automatic res_t mkres(input int id, input logic [1:0] fmt,
                                 input logic [3:0] err, input logic ab);
    res_t r;
    r.id = id; r.fmt = fmt; r.err = err; r.abort = ab;
    return r;
  endfunction

  // Requester r offers s one char per cycle; returns how many were accepted.
  task automatic drive_line(input int r, input string s, input int stall, output int sent);
    int t;
    sent = 0;
    t    = 0;
    forever begin
      @(negedge clk);
      if (sent >= s.len() || sent == stall) break;
      req_valid_i[r]         = 1'b1;
      req_char_i[8*r +: 8]   = s[sent];
      if (req_ready_o[r]) sent++;
      else if (sent > 0) break;
      else begin
        t++;
        if (t > 150) begin
          n_vec++;
          n_miss++;
          $display("FAIL grant_wait: req %0d not granted after %0d cycles", r, t);
          break;
        end
      end
    end
    req_valid_i[r]       = 1'b0;
    req_char_i[8*r +: 8] = 8'h00;
  endtask

  task automatic wait_results();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("results_drained", exp_q.size(), 0);
  endtask

  // Checker stand-in: verdict visible only in the cycle after it has seen '#'.
  initial begin
    bit h;
    chk_format_type_i = 2'd3;
    chk_error_code_i  = 4'hF;
    forever begin
      @(negedge clk);
      h = (out_char_o == 8'h23);
      @(posedge clk);
      #1;
      if (h && exp_q.size() != 0) begin
        chk_format_type_i = exp_q[0].fmt;
        chk_error_code_i  = exp_q[0].err;
      end else begin
        chk_format_type_i = 2'd3;
        chk_error_code_i  = 4'hF;
      end
    end
  end

  // Output monitor: char stream one cycle behind transfers, verdict scoreboard.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("out_char", out_char_o, exp_next);
        check("ready_onehot0", $onehot0(req_ready_o), 1);
        if (out_char_o == 8'h23) hash_cyc = cyc;
        if (exp_q.size() == 0) check("res_valid_idle", res_valid_o, 0);
        else if (res_valid_o) begin
          e = exp_q.pop_front();
          check("res_id", res_id_o, e.id);
          check("res_format", res_format_o, e.fmt);
          check("res_error", res_error_o, e.err);
          check("res_abort", res_abort_o, e.abort);
          if (!e.abort) check("res_latency", cyc, hash_cyc + 2);
        end
      end
      #2;
      exp_next = 8'h00;
      if (!reset)
        for (int k = 0; k < N_REQ; k++)
          if (req_valid_i[k] && req_ready_o[k]) exp_next = req_char_i[8*k +: 8];
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish by time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    string l1, l2, s64, s70;
    vec_t  vt[7];
    int    sent;
    l1  = "^1024@000030fc: $2 <= 89abcdef#";
    l2  = "^16@00002ffc: *00000010 <= 0000000f#";
    s64 = "^";
    for (int i = 0; i < 62; i++) s64 = {s64, "a"};
    s64 = {s64, "#"};
    s70 = "^";
    for (int i = 0; i < 69; i++) s70 = {s70, "b"};

    vt[0] = mk(0, l1,            -1, 2'd1, 4'd0, 1'b0, -1);
    vt[1] = mk(1, l2,            -1, 2'd2, 4'd2, 1'b0, -1);
    vt[2] = mk(3, l1,             5, 2'd0, 4'd0, 1'b1,  5);
    vt[3] = mk(2, "q no caret#", -1, 2'd0, 4'd0, 1'b0, -1);
    vt[4] = mk(0, s64,           -1, 2'd1, 4'd0, 1'b0, 64);
    vt[5] = mk(0, s70,           -1, 2'd0, 4'd0, 1'b1, 64);
    vt[6] = mk(1, "^7#",         -1, 2'd1, 4'd4, 1'b0, -1);

    reset       = 1'b1;
    req_valid_i = '0;
    req_char_i  = '0;
    repeat (3) @(negedge clk);
    check("rst_out_char", out_char_o, 8'h00);
    check("rst_req_ready", req_ready_o, 0);
    check("rst_res_valid", res_valid_o, 0);
    check("rst_res_id", res_id_o, 0);
    check("rst_res_format", res_format_o, 0);
    check("rst_res_error", res_error_o, 0);
    check("rst_res_abort", res_abort_o, 0);
    check("rst_busy", busy_o, 0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Req0 and req2 contend from reset: 0 first, then 2 even though 0 asks again.
    exp_q.push_back(mkres(0, 2'd1, 4'd0, 1'b0));
    exp_q.push_back(mkres(2, 2'd2, 4'd2, 1'b0));
    exp_q.push_back(mkres(0, 2'd1, 4'd3, 1'b0));
    fork
      begin
        drive_line(0, l1, -1, sent);
        drive_line(0, "^3#", -1, sent);
      end
      begin
        int s2;
        drive_line(2, l2, -1, s2);
      end
    join
    wait_results();

    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(mkres(vt[i].req, vt[i].fmt, vt[i].err, vt[i].abort));
      drive_line(vt[i].req, vt[i].line, vt[i].stall, sent);
      check($sformatf("sent_v%0d", i), sent, (vt[i].sent < 0) ? vt[i].line.len() : vt[i].sent);
      wait_results();
      check($sformatf("busy_after_v%0d", i), busy_o, 0);
    end

    // Reset in the middle of a req2 line: no verdict, stream and grants cleared.
    fork
      begin
        int s3;
        drive_line(2, l2, -1, s3);
      end
      begin
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_out_char", out_char_o, 8'h00);
        check("midrst_req_ready", req_ready_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_res_valid", res_valid_o, 0);
        reset = 1'b0;
      end
    join
    repeat (2) @(negedge clk);

    // Pointer back at N_REQ-1: req0 beats req3 although req2 was granted last.
    exp_q.push_back(mkres(0, 2'd1, 4'd0, 1'b0));
    exp_q.push_back(mkres(3, 2'd1, 4'd5, 1'b0));
    fork
      begin
        int s4;
        drive_line(0, l1, -1, s4);
      end
      begin
        int s5;
        drive_line(3, "^9#", -1, s5);
      end
    join
    wait_results();
    repeat (2) @(negedge clk);
    check("final_busy", busy_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
